// File: rtl/framer_input_scheduler.sv
// ============================================================================
// framer_input_scheduler
//
// Sits between the sampling ADC / debug-data-injection (DDI) source and the
// framer's sample inputs. Captures whole 128- or 256-sample ADC frames, powers
// the ADC down for a programmable number of frame periods between captures,
// and re-powers it early enough to finish its warm-up before the next capture.
// Source switching between ADC and DDI happens only at frame boundaries, so
// the framer never sees a partial frame or both sources in one cycle.
//
// Parameters
//   WARMUP_CYCLES    cycles the ADC must be powered before samples are used
//   SAMPLE_PERIOD    clock cycles per ADC sample, used to time skipped frames
//
// Ports
//   clk              system clock, rising edge
//   reset_n          asynchronous active-low reset
//   enable           run request
//   ddi_mode         1 = frames from DDI, 0 = frames from ADC
//   use_256_points   frame length 256 when 1, else 128
//   frame_skip_count frames skipped after each captured ADC frame
//   adc_sample_*     ADC strobe / sample in
//   ddi_in_*         DDI beat valid / data in; ddi_in_ready acknowledges
//   adc_power_on     ADC power enable (registered)
//   adc_valid/data   forwarded ADC sample to the framer (1-cycle latency)
//   ddi_valid/data   forwarded DDI beat to the framer (1-cycle latency)
//   frames_done      completed frames of either source, wraps at 2^16
// ============================================================================
module framer_input_scheduler #(
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_PERIOD = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        ddi_mode,
    input  logic        use_256_points,
    input  logic [6:0]  frame_skip_count,
    input  logic        adc_sample_valid,
    input  logic [7:0]  adc_sample_data,
    input  logic        ddi_in_valid,
    input  logic [7:0]  ddi_in_data,
    output logic        ddi_in_ready,
    output logic        adc_power_on,
    output logic        adc_valid,
    output logic [7:0]  adc_data,
    output logic        ddi_valid,
    output logic [7:0]  ddi_data,
    output logic [15:0] frames_done
);

    typedef enum logic [2:0] {IDLE, WARMUP, CAPTURE, SKIP, INJECT} state_t;

    localparam logic [7:0]  WARM_LOAD  = 8'(WARMUP_CYCLES);
    localparam logic [23:0] WARM_TIMER = 24'(WARMUP_CYCLES);
    localparam logic [23:0] SP24       = 24'(SAMPLE_PERIOD);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_warm_cnt, w_warm_nxt;
    logic [8:0]  r_sample_cnt, w_sample_nxt;
    logic [23:0] r_timer, w_timer_nxt;
    logic        r_n256, w_n256_nxt;
    logic [6:0]  r_skip, w_skip_nxt;
    logic [15:0] r_frames, w_frames_nxt;
    logic        r_power;
    logic        r_adc_valid, r_ddi_valid;
    logic [7:0]  r_adc_data, r_ddi_data;

    logic        w_adc_take, w_ddi_take;
    logic [8:0]  w_frame_last;
    logic [23:0] w_skip_prod, w_skip_load;

    // A sample or beat only counts in the state that owns that source.
    assign w_adc_take   = (r_state == CAPTURE) && adc_sample_valid;
    assign w_ddi_take   = (r_state == INJECT) && ddi_in_valid;
    assign w_frame_last = r_n256 ? 9'd255 : 9'd127;

    // Skip length is never shorter than the warm-up, otherwise the ADC could
    // not be fully warmed before the next capture.
    assign w_skip_prod  = 24'(r_skip) * (r_n256 ? 24'd256 : 24'd128) * SP24;
    assign w_skip_load  = (w_skip_prod > WARM_TIMER) ? w_skip_prod : WARM_TIMER;

    // Next-state and counter logic. Shadow N/skip are refreshed on leaving
    // IDLE and at every frame boundary so a frame never changes length midway.
    always_comb begin
        w_state_nxt  = r_state;
        w_warm_nxt   = r_warm_cnt;
        w_sample_nxt = r_sample_cnt;
        w_timer_nxt  = r_timer;
        w_n256_nxt   = r_n256;
        w_skip_nxt   = r_skip;
        w_frames_nxt = r_frames;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_n256_nxt   = use_256_points;
                    w_skip_nxt   = frame_skip_count;
                    w_sample_nxt = 9'd0;
                    if (ddi_mode) begin
                        w_state_nxt = INJECT;
                    end else begin
                        w_state_nxt = WARMUP;
                        w_warm_nxt  = WARM_LOAD;
                    end
                end
            end
            WARMUP: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (r_warm_cnt == 8'd0) begin
                    w_state_nxt  = CAPTURE;
                    w_sample_nxt = 9'd0;
                end else begin
                    w_warm_nxt = r_warm_cnt - 8'd1;
                end
            end
            CAPTURE: begin
                if (w_adc_take) begin
                    if (r_sample_cnt == w_frame_last) begin
                        w_frames_nxt = r_frames + 16'd1;
                        w_sample_nxt = 9'd0;
                        w_n256_nxt   = use_256_points;
                        w_skip_nxt   = frame_skip_count;
                        if (!enable) begin
                            w_state_nxt = IDLE;
                        end else if (ddi_mode) begin
                            w_state_nxt = INJECT;
                        end else if (r_skip != 7'd0) begin
                            w_state_nxt = SKIP;
                            w_timer_nxt = w_skip_load;
                        end
                    end else begin
                        w_sample_nxt = r_sample_cnt + 9'd1;
                    end
                end
            end
            SKIP: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (r_timer == 24'd0) begin
                    w_state_nxt  = CAPTURE;
                    w_sample_nxt = 9'd0;
                end else begin
                    w_timer_nxt = r_timer - 24'd1;
                end
            end
            INJECT: begin
                if (w_ddi_take) begin
                    if (r_sample_cnt == w_frame_last) begin
                        w_frames_nxt = r_frames + 16'd1;
                        w_sample_nxt = 9'd0;
                        w_n256_nxt   = use_256_points;
                        w_skip_nxt   = frame_skip_count;
                        if (!enable) begin
                            w_state_nxt = IDLE;
                        end else if (!ddi_mode) begin
                            w_state_nxt = WARMUP;
                            w_warm_nxt  = WARM_LOAD;
                        end
                    end else begin
                        w_sample_nxt = r_sample_cnt + 9'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, counters and registered framer outputs. Power follows the
    // current state one cycle later; in SKIP it comes back once the remaining
    // time has dropped to the warm-up length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_warm_cnt   <= 8'd0;
            r_sample_cnt <= 9'd0;
            r_timer      <= 24'd0;
            r_n256       <= 1'b0;
            r_skip       <= 7'd0;
            r_frames     <= 16'd0;
            r_power      <= 1'b0;
            r_adc_valid  <= 1'b0;
            r_adc_data   <= 8'd0;
            r_ddi_valid  <= 1'b0;
            r_ddi_data   <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_warm_cnt   <= w_warm_nxt;
            r_sample_cnt <= w_sample_nxt;
            r_timer      <= w_timer_nxt;
            r_n256       <= w_n256_nxt;
            r_skip       <= w_skip_nxt;
            r_frames     <= w_frames_nxt;
            r_power      <= (r_state == WARMUP) || (r_state == CAPTURE) ||
                            ((r_state == SKIP) && (r_timer <= WARM_TIMER));
            r_adc_valid  <= w_adc_take;
            r_adc_data   <= w_adc_take ? adc_sample_data : 8'd0;
            r_ddi_valid  <= w_ddi_take;
            r_ddi_data   <= w_ddi_take ? ddi_in_data : 8'd0;
        end
    end

    assign ddi_in_ready = (r_state == INJECT);
    assign adc_power_on = r_power;
    assign adc_valid    = r_adc_valid;
    assign adc_data     = r_adc_data;
    assign ddi_valid    = r_ddi_valid;
    assign ddi_data     = r_ddi_data;
    assign frames_done  = r_frames;

endmodule

// File: tb/tb_framer_input_scheduler.sv
// ============================================================================
// tb_framer_input_scheduler
//
// Directed bench for framer_input_scheduler. A short table of stimulus
// records walks a DDI frame, the switch back to ADC and a disabled ADC frame;
// hand-written sequences then cover continuous capture, skip/power timing,
// disable in SKIP, DDI backpressure, a mid-frame mode switch and a mid-frame
// reset. A second instance (WARMUP_CYCLES=200, SAMPLE_PERIOD=1) covers the
// short-skip case where the warm-up dominates the skip time.
// ============================================================================
module tb_framer_input_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable, enB, ddi_mode, use_256_points;
   logic [6:0]  frame_skip_count;
   logic        adc_sample_valid;
   logic [7:0]  adc_sample_data;
   logic        ddi_in_valid;
   logic [7:0]  ddi_in_data;

   logic        ddi_in_ready, adc_power_on, adc_valid, ddi_valid;
   logic [7:0]  adc_data, ddi_data;
   logic [15:0] frames_done;

   logic        bReady, bPower, bAdcValid, bDdiValid;
   logic [7:0]  bAdcData, bDdiData;
   logic [15:0] bFrames;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int aPer = 0;
   bit dAuto = 1'b0;

   int adcCount = 0, ddiCount = 0, powerLow = 0;
   int latErr = 0, zeroErr = 0, overlapErr = 0;
   int adcCountB = 0, powerLowB = 0;
   logic       prevAv, prevDv;
   logic [7:0] prevAd, prevDd;

   typedef struct {
      logic en;
      logic ddi;
      logic av;
      logic dv;
      int   reps;
      logic power;
      logic aValid;
      logic dValid;
      logic ready;
      int   frames;
   } vec_t;

   vec_t vecs[12];

   framer_input_scheduler #(.WARMUP_CYCLES(64), .SAMPLE_PERIOD(16)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .ddi_mode(ddi_mode),
      .use_256_points(use_256_points), .frame_skip_count(frame_skip_count),
      .adc_sample_valid(adc_sample_valid), .adc_sample_data(adc_sample_data),
      .ddi_in_valid(ddi_in_valid), .ddi_in_data(ddi_in_data),
      .ddi_in_ready(ddi_in_ready), .adc_power_on(adc_power_on),
      .adc_valid(adc_valid), .adc_data(adc_data),
      .ddi_valid(ddi_valid), .ddi_data(ddi_data), .frames_done(frames_done)
   );

   framer_input_scheduler #(.WARMUP_CYCLES(200), .SAMPLE_PERIOD(1)) dutB (
      .clk(clk), .reset_n(reset_n), .enable(enB), .ddi_mode(ddi_mode),
      .use_256_points(use_256_points), .frame_skip_count(frame_skip_count),
      .adc_sample_valid(adc_sample_valid), .adc_sample_data(adc_sample_data),
      .ddi_in_valid(ddi_in_valid), .ddi_in_data(ddi_in_data),
      .ddi_in_ready(bReady), .adc_power_on(bPower),
      .adc_valid(bAdcValid), .adc_data(bAdcData),
      .ddi_valid(bDdiValid), .ddi_data(bDdiData), .frames_done(bFrames)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Watchdog so the run always ends even if a wait loop misbehaves.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Remember what was offered on each edge so the forwarded value one cycle
   // later can be compared against it.
   always @(posedge clk) begin
      prevAv <= adc_sample_valid;
      prevAd <= adc_sample_data;
      prevDv <= ddi_in_valid;
      prevDd <= ddi_in_data;
   end

   // Continuous monitor: counts forwarded strobes and power-off cycles, and
   // flags latency, zero-data and overlap violations for the final checks.
   always @(negedge clk) begin
      if (adc_valid) begin
         adcCount <= adcCount + 1;
         if (!prevAv || adc_data != prevAd) latErr <= latErr + 1;
      end else if (adc_data != 8'd0) begin
         zeroErr <= zeroErr + 1;
      end
      if (ddi_valid) begin
         ddiCount <= ddiCount + 1;
         if (!prevDv || ddi_data != prevDd) latErr <= latErr + 1;
      end else if (ddi_data != 8'd0) begin
         zeroErr <= zeroErr + 1;
      end
      if (adc_valid && ddi_valid) overlapErr <= overlapErr + 1;
      if (!adc_power_on) powerLow <= powerLow + 1;
      if (bAdcValid) adcCountB <= adcCountB + 1;
      if (!bPower) powerLowB <= powerLowB + 1;
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock: update ramps and automatic strobes, then settle just
   // after the falling edge so outputs are sampled away from the active edge.
   task automatic tick();
      adc_sample_data = adc_sample_data + 8'd1;
      ddi_in_data     = ddi_in_data + 8'd7;
      if (aPer > 0) adc_sample_valid = ((cyc % aPer) == 0);
      if (dAuto) ddi_in_valid = ((cyc % 3) != 2);
      cyc++;
      @(negedge clk);
      #1;
   endtask

   // Apply one table record for its repeat count, then check the outputs.
   task automatic applyStimulus(input int idx, input vec_t v);
      enable           = v.en;
      ddi_mode         = v.ddi;
      adc_sample_valid = v.av;
      ddi_in_valid     = v.dv;
      repeat (v.reps) tick();
      checkOutput($sformatf("vec%0d power", idx), adc_power_on, v.power);
      checkOutput($sformatf("vec%0d adc_valid", idx), adc_valid, v.aValid);
      checkOutput($sformatf("vec%0d ddi_valid", idx), ddi_valid, v.dValid);
      checkOutput($sformatf("vec%0d ready", idx), ddi_in_ready, v.ready);
      checkOutput($sformatf("vec%0d frames", idx), frames_done, v.frames);
   endtask

   task automatic waitFrames(input int target, input int bound);
      for (int k = 0; k < bound && frames_done != 16'(target); k++) tick();
      checkOutput($sformatf("frames reach %0d", target), frames_done, target);
   endtask

   task automatic waitAdc(input int target, input int bound);
      for (int k = 0; k < bound && adcCount < target; k++) tick();
      checkOutput("adc sample count reach", adcCount, target);
   endtask

   int base, base2, dbase, pl, low, c;

   initial begin
      reset_n = 1'b0;
      enable = 1'b0; enB = 1'b0; ddi_mode = 1'b0; use_256_points = 1'b0;
      frame_skip_count = 7'd0; adc_sample_valid = 1'b0; adc_sample_data = 8'd0;
      ddi_in_valid = 1'b0; ddi_in_data = 8'd0;

      // Reset state.
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset power", adc_power_on, 0);
      checkOutput("reset adc_valid", adc_valid, 0);
      checkOutput("reset adc_data", adc_data, 0);
      checkOutput("reset ddi_valid", ddi_valid, 0);
      checkOutput("reset ddi_data", ddi_data, 0);
      checkOutput("reset frames", frames_done, 0);
      checkOutput("reset ready", ddi_in_ready, 0);
      reset_n = 1'b1;

      // DDI frame of 128, switch to ADC, warm-up, one ADC frame then disable.
      //            en    ddi   av    dv    reps pwr  aV   dV   rdy  frames
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2,   1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,   1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,   1'b0, 1'b0, 1'b1, 1'b1, 0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3,   1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 126, 1'b0, 1'b0, 1'b1, 1'b1, 0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,   1'b0, 1'b0, 1'b1, 1'b0, 1};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,   1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 63,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,   1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,   1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 127, 1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,   1'b0, 1'b0, 1'b0, 1'b0, 2};
      for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);

      // Continuous capture, N=128, skip=0, strobe every 16 cycles.
      aPer = 16;
      ddi_in_valid = 1'b0;
      ddi_mode = 1'b0; use_256_points = 1'b0; frame_skip_count = 7'd0;
      enable = 1'b1;
      base = adcCount;
      tick();
      checkOutput("power before rise", adc_power_on, 0);
      tick();
      checkOutput("power rise", adc_power_on, 1);
      pl = powerLow;
      repeat (63) tick();
      checkOutput("no adc_valid in warmup", adcCount - base, 0);
      waitFrames(4, 4400);
      checkOutput("continuous samples", adcCount - base, 256);
      checkOutput("continuous power held", powerLow - pl, 0);

      // Skip timing, skip=2: power off 4032 cycles, on 64 before capture.
      frame_skip_count = 7'd2;
      waitFrames(6, 4400);
      checkOutput("power at boundary", adc_power_on, 1);
      low = 0;
      tick();
      for (int k = 0; k < 5000 && !adc_power_on; k++) begin
         low++;
         tick();
      end
      checkOutput("skip power-off cycles", low, 4032);
      pl = powerLow;
      c = 0;
      for (int k = 0; k < 200 && !adc_valid; k++) begin
         tick();
         c++;
      end
      checkOutput("power-on to first sample in 65..80", (c >= 65 && c <= 80) ? 1 : 0, 1);
      checkOutput("power held through warm-up", powerLow - pl, 0);

      // Disable in SKIP goes straight to IDLE.
      waitFrames(7, 2400);
      repeat (10) tick();
      checkOutput("power off in skip", adc_power_on, 0);
      enable = 1'b0;
      repeat (2) tick();
      checkOutput("power off after disable", adc_power_on, 0);
      checkOutput("frames after disable", frames_done, 7);
      use_256_points = 1'b1; frame_skip_count = 7'd0; ddi_mode = 1'b1; enable = 1'b1;
      base = adcCount;
      tick();
      checkOutput("inject after idle ready", ddi_in_ready, 1);

      // DDI backpressure, N=256, then exit to WARMUP.
      ddi_mode = 1'b0;
      dAuto = 1'b1;
      dbase = ddiCount;
      waitFrames(8, 500);
      checkOutput("ddi beats forwarded", ddiCount - dbase, 256);
      checkOutput("ready drops after inject", ddi_in_ready, 0);
      checkOutput("power off during inject", adc_power_on, 0);
      checkOutput("no adc during inject", adcCount - base, 0);
      tick();
      checkOutput("power rise after inject", adc_power_on, 1);
      repeat (5) tick();
      checkOutput("no ddi beats in warmup", ddiCount - dbase, 256);

      // Mode switch at sample 50 of a 256-sample frame.
      base = adcCount;
      waitAdc(base + 50, 65 + 50 * 16 + 60);
      ddi_mode = 1'b1;
      waitFrames(9, 206 * 16 + 100);
      checkOutput("adc frame completes", adcCount - base, 256);
      checkOutput("ready on inject entry", ddi_in_ready, 1);
      dbase = ddiCount;
      base2 = adcCount;
      tick();
      checkOutput("power off in inject", adc_power_on, 0);
      ddi_mode = 1'b0;
      waitFrames(10, 500);
      checkOutput("ddi frame beats", ddiCount - dbase, 256);
      checkOutput("no adc in inject", adcCount - base2, 0);

      // Reset at sample 70 of an ADC frame.
      base = adcCount;
      waitAdc(base + 70, 65 + 70 * 16 + 60);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset power", adc_power_on, 0);
      checkOutput("async reset adc_valid", adc_valid, 0);
      checkOutput("async reset adc_data", adc_data, 0);
      checkOutput("async reset ddi_valid", ddi_valid, 0);
      checkOutput("async reset frames", frames_done, 0);
      checkOutput("async reset ready", ddi_in_ready, 0);
      enable = 1'b0;
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      base = adcCount;
      repeat (20) tick();
      checkOutput("frames after reset", frames_done, 0);
      checkOutput("power after reset", adc_power_on, 0);
      checkOutput("no strobes after reset", adcCount - base, 0);

      // Short skip on the second instance: skip time is the 200-cycle warm-up.
      aPer = 1;
      dAuto = 1'b0;
      ddi_in_valid = 1'b0;
      ddi_mode = 1'b0; use_256_points = 1'b0; frame_skip_count = 7'd1;
      enB = 1'b1;
      for (int k = 0; k < 450 && bFrames != 16'd1; k++) tick();
      checkOutput("short skip first frame", bFrames, 1);
      pl = powerLowB;
      c = 0;
      do begin
         tick();
         c++;
      end while (!bAdcValid && c < 400);
      checkOutput("short skip gap to next sample", c, 202);
      checkOutput("short skip power held", powerLowB - pl, 0);

      // Whole-run monitor results.
      checkOutput("forwarding latency errors", latErr, 0);
      checkOutput("data nonzero without valid", zeroErr, 0);
      checkOutput("adc/ddi valid overlap", overlapErr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
